rc_cmp_pulse_meter: RTL and testbench
=====================================

// Module: rc_cmp_pulse_meter
// PURPOSE
//  Receive-side measurement of the RC comparator output. Synchronises the raw
//  comparator bit, rejects glitches and measures each high pulse in clk cycles.
//  Presents each measurement on a valid/ready port to the checker/logger that
//  sits beside rc_cmp_width_wrapper in the testbench.
// PARAMETERS
//  WIDTH        16  width of the pulse-length counter and result
//  SYNC_STAGES  2   flops in the cmp_in synchroniser (>=2)
//  MIN_PULSE    2   pulses shorter than this (cycles) are glitches and are discarded
// PORTS
//  clk          in   1      system clock, all logic on rising edge
//  rst          in   1      synchronous reset, active-low (0 = reset)
//  en           in   1      measurement enable; 0 forces return to IDLE
//  cmp_in       in   1      asynchronous comparator output
//  width_out    out  WIDTH  measured high time in cycles, stable while width_valid
//  width_valid  out  1      result available
//  width_ready  in   1      consumer accepts; transfer = valid & ready at clk edge
//  saturated    out  1      qualifies width_out: counter hit 2**WIDTH-1
//  glitch_cnt   out  8      count of discarded pulses, saturates at 255
//  busy         out  1      high in MEASURE or REPORT
// BEHAVIOUR
//  Reset (rst=0 at edge): state IDLE, synchroniser flops 0, width_out=0,
//   width_valid=0, saturated=0, glitch_cnt=0, busy=0. Reset overrides everything,
//   including mid-pulse and a pending report (result lost).
//  cmp_s = last synchroniser stage; FSM sees cmp_in only through cmp_s.
//  IDLE    : wait for en=1 and cmp_s=0 -> ARMED (a pulse already high at enable is
//            never measured).
//  ARMED   : cmp_s=1 -> MEASURE, cnt<=1.
//  MEASURE : cmp_s=1 -> cnt<=cnt+1, saturating at 2**WIDTH-1 (sat flag set, holds).
//            cmp_s=0 and cnt>=MIN_PULSE -> width_out<=cnt, saturated<=sat,
//            width_valid<=1, REPORT.
//            cmp_s=0 and cnt<MIN_PULSE -> glitch_cnt+=1 (sat at 255), ARMED.
//  REPORT  : hold width_out/saturated/width_valid; on valid&ready -> width_valid<=0,
//            cnt/sat cleared, -> IDLE (re-arms only after cmp_s seen low).
//            Pulses arriving while in REPORT are ignored, not counted as glitches.
//  en=0 in any state -> IDLE next edge, width_valid<=0 (pending result dropped);
//   glitch_cnt retained.
//  Latency: N-cycle pulse on cmp_in -> width_out=N; width_valid rises at edge
//   e0+SYNC_STAGES, e0 = first edge sampling cmp_in=0 after the pulse.
//  width_valid never drops without a transfer except on reset or en=0.
//  Pulse exactly MIN_PULSE long is reported; MIN_PULSE-1 is a glitch.
//  ready held high continuously: one result per pulse, no back-pressure stall.
// STRUCTURE
//  Package rc_cmp_pkg: typedef enum logic [1:0] {IDLE, ARMED, MEASURE, REPORT}
//   meter_state_t; localparam CMP_WIDTH_DEFAULT=16; GLITCH_CNT_W=8.
//  Sub-module rc_cmp_sync: SYNC_STAGES-deep synchroniser, synchronous active-low
//   reset to 0, output cmp_s. FSM, counter and output regs stay in this module.
// TESTING
//  1 rst=0 for 3 cycles, cmp_in toggling -> all outputs 0, state IDLE, busy=0.
//  2 en=1, ready=1, cmp_in high 10 cycles -> width_out=10, saturated=0, one-cycle
//    width_valid at e0+2.
//  3 cmp_in high 1 cycle (MIN_PULSE=2) -> no valid, glitch_cnt=1; then 2-cycle
//    pulse -> width_out=2.
//  4 ready=0, pulses of 5 then 7 -> width_out=5 held; ready=1 -> transfer 5, the
//    7-cycle pulse (overlapping REPORT) not reported; next 3-cycle pulse reports 3.
//  5 WIDTH=4, 20-cycle pulse -> width_out=15, saturated=1.
//  6 rst=0 mid-MEASURE (and separately en=0 in REPORT) -> valid=0, IDLE; cmp_in
//    already high at release is not measured; next full pulse measured correctly.

Source files
------------

// File: rtl/rc_cmp_pkg.sv
// Shared types and constants for the RC comparator pulse meter.
package rc_cmp_pkg;

   typedef enum logic [1:0] {IDLE, ARMED, MEASURE, REPORT} meter_state_t;

   localparam int CMP_WIDTH_DEFAULT = 16;
   localparam int GLITCH_CNT_W      = 8;

endpackage

// File: rtl/rc_cmp_sync.sv
// Multi-flop synchroniser bringing the asynchronous comparator bit into clk.
module rc_cmp_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic cmp_in,
   output logic cmp_s
);

   logic [SYNC_STAGES-1:0] sync_q;

   // NOTE: sequential state uses <= so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst) sync_q <= '0;
      else      sync_q <= {sync_q[SYNC_STAGES-2:0], cmp_in};
   end

   assign cmp_s = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/rc_cmp_pulse_meter.sv
// Measures glitch-filtered high pulses of the synchronised comparator bit and
// reports each width on a valid/ready port.
module rc_cmp_pulse_meter
   import rc_cmp_pkg::*;
#(
   parameter int WIDTH       = CMP_WIDTH_DEFAULT,
   parameter int SYNC_STAGES = 2,
   parameter int MIN_PULSE   = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic                    cmp_in,
   output logic [WIDTH-1:0]        width_out,
   output logic                    width_valid,
   input  logic                    width_ready,
   output logic                    saturated,
   output logic [GLITCH_CNT_W-1:0] glitch_cnt,
   output logic                    busy
);

   localparam logic [WIDTH-1:0]        CNT_MAX    = '1;
   localparam logic [WIDTH-1:0]        MIN_LEN    = WIDTH'(MIN_PULSE);
   localparam logic [GLITCH_CNT_W-1:0] GLITCH_MAX = '1;

   meter_state_t            state, state_d;
   logic [WIDTH-1:0]        cnt, cnt_d, width_d;
   logic                    sat, sat_d, saturated_d, valid_d;
   logic [GLITCH_CNT_W-1:0] glitch_d;
   logic [SYNC_STAGES-1:0]  fill;
   logic                    primed, cmp_s;

   rc_cmp_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk    (clk),
      .rst    (rst),
      .cmp_in (cmp_in),
      .cmp_s  (cmp_s)
   );

   // The synchroniser holds stale zeros right after reset; don't arm until
   // cmp_s reflects samples taken after reset release.
   assign primed = fill[SYNC_STAGES-1];

   always_ff @(posedge clk) begin
      if (!rst) begin
         state       <= IDLE;
         cnt         <= '0;
         sat         <= 1'b0;
         width_out   <= '0;
         saturated   <= 1'b0;
         width_valid <= 1'b0;
         glitch_cnt  <= '0;
         fill        <= '0;
      end else begin
         state       <= state_d;
         cnt         <= cnt_d;
         sat         <= sat_d;
         width_out   <= width_d;
         saturated   <= saturated_d;
         width_valid <= valid_d;
         glitch_cnt  <= glitch_d;
         fill        <= {fill[SYNC_STAGES-2:0], 1'b1};
      end
   end

   always_comb begin
      // NOTE: every next-state value is defaulted first so no path infers a latch.
      state_d     = state;
      cnt_d       = cnt;
      sat_d       = sat;
      width_d     = width_out;
      saturated_d = saturated;
      valid_d     = width_valid;
      glitch_d    = glitch_cnt;

      if (!en) begin
         state_d = IDLE;
         valid_d = 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (primed && !cmp_s) state_d = ARMED;
            end
            ARMED: begin
               if (cmp_s) begin
                  state_d = MEASURE;
                  cnt_d   = WIDTH'(1);
                  sat_d   = 1'b0;
               end
            end
            MEASURE: begin
               if (cmp_s) begin
                  if (cnt != CNT_MAX) cnt_d = cnt + WIDTH'(1);
                  sat_d = (cnt_d == CNT_MAX);
               end else if (cnt >= MIN_LEN) begin
                  width_d     = cnt;
                  saturated_d = sat;
                  valid_d     = 1'b1;
                  state_d     = REPORT;
               end else begin
                  if (glitch_cnt != GLITCH_MAX) glitch_d = glitch_cnt + GLITCH_CNT_W'(1);
                  cnt_d   = '0;
                  state_d = ARMED;
               end
            end
            REPORT: begin
               if (width_ready) begin
                  valid_d = 1'b0;
                  cnt_d   = '0;
                  sat_d   = 1'b0;
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign busy = (state == MEASURE) || (state == REPORT);

endmodule

// File: tb/tb_rc_cmp_pulse_meter.sv
// Scoreboard bench: two meters (WIDTH=16 and WIDTH=4) share stimulus; a monitor
// pops expected widths on every valid&ready transfer.
module tb_rc_cmp_pulse_meter;
   import rc_cmp_pkg::*;

   typedef struct {
      int w;
      bit s;
      int rise;
   } exp_t;

   logic        clk, rst, en, cmp_in, ready;
   logic [15:0] w16;
   logic [3:0]  w4;
   logic        v16, v4, s16, s4, b16, b4;
   logic [7:0]  g16, g4;

   exp_t q16[$];
   exp_t q4[$];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   int   gexp  = 0;

   rc_cmp_pulse_meter #(.WIDTH(16), .SYNC_STAGES(2), .MIN_PULSE(2)) dut16 (
      .clk(clk), .rst(rst), .en(en), .cmp_in(cmp_in),
      .width_out(w16), .width_valid(v16), .width_ready(ready),
      .saturated(s16), .glitch_cnt(g16), .busy(b16)
   );

   rc_cmp_pulse_meter #(.WIDTH(4), .SYNC_STAGES(2), .MIN_PULSE(2)) dut4 (
      .clk(clk), .rst(rst), .en(en), .cmp_in(cmp_in),
      .width_out(w4), .width_valid(v4), .width_ready(ready),
      .saturated(s4), .glitch_cnt(g4), .busy(b4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input longint act, input longint req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Monitor: samples just after the stimulus edge so valid/ready are settled.
   logic v16_q = 1'b0, v4_q = 1'b0;
   int   rise16 = 0, rise4 = 0;
   always @(negedge clk) begin
      exp_t e;
      #1;
      if (!rst) begin
         v16_q = 1'b0;
         v4_q  = 1'b0;
      end else begin
         if (v16 && !v16_q) rise16 = cyc;
         if (v4 && !v4_q)   rise4  = cyc;
         v16_q = v16;
         v4_q  = v4;
         if (v16 && ready) begin
            if (q16.size() == 0) check("w16_unexpected_valid", v16, 0);
            else begin
               e = q16.pop_front();
               check("w16_width", w16, e.w);
               check("w16_sat", s16, e.s);
               check("w16_rise_cycle", rise16, e.rise);
            end
         end
         if (v4 && ready) begin
            if (q4.size() == 0) check("w4_unexpected_valid", v4, 0);
            else begin
               e = q4.pop_front();
               check("w4_width", w4, e.w);
               check("w4_sat", s4, e.s);
               check("w4_rise_cycle", rise4, e.rise);
            end
         end
      end
   end

   // Drive an n-cycle high pulse; valid is due at e0+2, e0 being one edge
   // after the negedge where cmp_in drops.
   task automatic pulse(input int n, input bit rep, input int gap);
      exp_t e;
      cmp_in = 1'b1;
      repeat (n) @(negedge clk);
      cmp_in = 1'b0;
      if (rep) begin
         e.w = n; e.s = 1'b0; e.rise = cyc + 3;
         q16.push_back(e);
         e.w = (n > 15) ? 15 : n; e.s = (n >= 15);
         q4.push_back(e);
      end
      repeat (gap) @(negedge clk);
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_v16"}, v16, 0);
      check({tag, "_v4"}, v4, 0);
      check({tag, "_busy16"}, b16, 0);
      check({tag, "_busy4"}, b4, 0);
      check({tag, "_state16"}, dut16.state, IDLE);
   endtask

   initial begin
      rst = 1'b0; en = 1'b0; ready = 1'b0; cmp_in = 1'b0;

      // 1: reset with cmp_in toggling
      repeat (3) begin
         @(negedge clk);
         cmp_in = ~cmp_in;
      end
      @(negedge clk);
      check_idle_outputs("reset");
      check("reset_w16", w16, 0);
      check("reset_sat16", s16, 0);
      check("reset_glitch16", g16, 0);
      cmp_in = 1'b0;
      rst = 1'b1;
      repeat (4) @(negedge clk);

      // 2: 10-cycle pulse, busy during measurement
      en = 1'b1; ready = 1'b1;
      repeat (4) @(negedge clk);
      cmp_in = 1'b1;
      repeat (6) @(negedge clk);
      check("measure_busy16", b16, 1);
      repeat (4) @(negedge clk);
      begin
         exp_t e;
         cmp_in = 1'b0;
         e.w = 10; e.s = 1'b0; e.rise = cyc + 3;
         q16.push_back(e);
         q4.push_back(e);
      end
      repeat (8) @(negedge clk);

      // 3: glitch then minimum-length pulse
      pulse(1, 1'b0, 8);
      gexp = 1;
      check("glitch16_after_1", g16, gexp);
      check("glitch4_after_1", g4, gexp);
      pulse(2, 1'b1, 8);

      // 4: back-pressure; pulse during REPORT is ignored
      ready = 1'b0;
      pulse(5, 1'b1, 4);
      pulse(7, 1'b0, 4);
      check("held_valid16", v16, 1);
      check("held_width16", w16, 5);
      check("held_busy16", b16, 1);
      ready = 1'b1;
      repeat (6) @(negedge clk);
      pulse(3, 1'b1, 8);
      check("glitch16_after_report", g16, gexp);

      // 5: 20-cycle pulse saturates the 4-bit meter only
      pulse(20, 1'b1, 8);

      // 6a: reset mid-measure, pulse still high at release
      cmp_in = 1'b1;
      repeat (5) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check_idle_outputs("midrst");
      check("midrst_glitch16", g16, 0);
      gexp = 0;
      rst = 1'b1;
      repeat (6) @(negedge clk);
      cmp_in = 1'b0;
      repeat (6) @(negedge clk);
      check("postrst_busy16", b16, 0);
      pulse(6, 1'b1, 8);

      // 6b: en=0 in REPORT drops the result
      ready = 1'b0;
      pulse(4, 1'b0, 4);
      check("pending_valid16", v16, 1);
      en = 1'b0;
      cmp_in = 1'b1;
      @(negedge clk);
      check_idle_outputs("en_off");
      check("en_off_glitch16", g16, gexp);
      repeat (2) @(negedge clk);
      en = 1'b1;
      ready = 1'b1;
      repeat (5) @(negedge clk);
      cmp_in = 1'b0;
      repeat (6) @(negedge clk);
      check("en_on_busy16", b16, 0);
      pulse(9, 1'b1, 8);

      repeat (4) @(negedge clk);
      check("q16_drained", q16.size(), 0);
      check("q4_drained", q4.size(), 0);
      check("final_glitch4", g4, gexp);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1);
   end

endmodule
